mmc3_scanline_irq: RTL and testbench
====================================

# mmc3_scanline_irq

Scanline IRQ generator for the MMC3-family mappers. It watches PPU A12 from the mapper's CHR address path and filters out spurious toggles. It counts qualified rising edges against a CPU-programmed latch and drives the cartridge `irq` line that the top level exports. It sits between the CPU register-write decoder, which feeds it, and the top-level `irq` pin.

## Interface
Parameters:
- `A12_LOW_MIN`, default 3: minimum consecutive `m2` cycles with synchronized A12 low before a rising edge counts.
- `FILTER_BITS`, default 2: width of the A12-low counter. It must satisfy `2**FILTER_BITS - 1 >= A12_LOW_MIN`.

Ports:
- `m2`  in  1: the only clock. All state updates on posedge.
- `reset`  in  1: synchronous, active-high reset.
- `ppu_a12`  in  1: raw `ppu_addr_in[12]`. Asynchronous to `m2`.
- `reg_wr`  in  1: one-cycle write strobe from the register decoder.
- `reg_sel`  in  2: selects the register.
  - 0 = latch ($C000)
  - 1 = reload ($C001)
  - 2 = disable/ack ($E000)
  - 3 = enable ($E001)
- `reg_data`  in  8: CPU write data. Used only when `reg_sel` = 0.
- `irq_n`  out  1: active-low IRQ request.
- `counter_dbg`  out  8: current counter value, for debug readback.

## Operation
- Synchronizer: 2-flop chain on `ppu_a12`. Call the synchronized value `a12_s` and its previous value `a12_d`.
- Low filter:
  - `low_cnt` increments while `a12_s` = 0 and saturates at `A12_LOW_MIN`.
  - It clears in any cycle where `a12_s` = 1.
- Qualified edge: `a12_s & ~a12_d & (low_cnt == A12_LOW_MIN)`.
- State: `latch[7:0]`, `counter[7:0]`, `reload` flag, `enabled`, `pending`.
- Register writes:
  - sel 0: `latch <= reg_data`.
  - sel 1: `counter <= 0` and `reload <= 1`.
  - sel 2: `enabled <= 0` and `pending <= 0`.
  - sel 3: `enabled <= 1`.
- On a qualified edge:
  - If `counter == 0` or `reload` is set: `counter <= latch` and `reload <= 0`.
  - Otherwise: `counter <= counter - 1`, 8-bit with no wrap below 0.
  - The IRQ check below is made on the new counter value.
- IRQ set: `pending <= 1` when the new counter is 0 and `enabled` is 1.
- `irq_n = ~pending`, taken directly from the register.
- Simultaneous events in the same cycle:
  - Write plus edge: the write is applied first, then the edge is evaluated on the post-write state. So a same-cycle latch write is loaded, and a same-cycle reload forces a latch load.
  - sel 2 plus an edge reaching zero: the IRQ is not set, because disable wins.
  - sel 3 plus an edge reaching zero: the IRQ is set.
- `pending` stays set until sel 2 or reset. Further edges do not clear it.
- Reset values:
  - `latch`, `counter`, `low_cnt` = 0.
  - `reload`, `enabled`, `pending` = 0.
  - Synchronizer flops = 0.
  - `irq_n` = 1; `counter_dbg` = 0.
- Reset mid-operation discards any edge in the synchronizer.

## Timing
- Pin to `a12_s`: 2 cycles.
- Edge evaluation happens in the cycle `a12_s` first reads 1. Counter and `pending` update at the end of that cycle.
- `irq_n` falls 1 cycle after the edge-evaluation cycle, i.e. 3 `m2` cycles after A12 rises at the pin.
- A write takes effect at the end of its strobe cycle. An sel 2 write in cycle N raises `irq_n` in cycle N+1.
- Minimum edge spacing: A12 must be low for at least `A12_LOW_MIN` synchronized cycles. A12 pulses within the same scanline's sprite fetches produce exactly one count.

## Configuration
- `MMC3_ALT_IRQ_EN` defined: alternate (Rev A / NEC) behaviour.
  - `pending` is set only when the counter reaches 0 by decrement, or by reload from a nonzero latch.
  - Reload with `latch` = 0 does not raise an IRQ.
- Not defined: standard (Rev B / Sharp) behaviour. The IRQ is set whenever the post-edge counter is 0 and enabled, so `latch` = 0 raises an IRQ on every edge.

## Test plan
- Basic countdown:
  - Stimulus: reset; latch 3; reload; enable; A12 pulses high 2 / low 8 cycles.
  - Required response: counter goes 3, 2, 1, 0; `irq_n` low 3 cycles after the 4th pulse's pin rise.
- Glitch filter:
  - Stimulus: A12 low for only 2 cycles between highs, with `A12_LOW_MIN` = 3.
  - Required response: the second rise is not counted and `counter_dbg` is unchanged.
- Acknowledge and stickiness:
  - Stimulus: with the IRQ pending, apply 2 more qualified edges, then write sel 2.
  - Required response: `irq_n` stays low through both edges, then is high the cycle after the write. The counter has reloaded to the latch value.
- Simultaneous events:
  - Stimulus: latch 5 written in the same cycle as an edge while counter = 0.
  - Required response: counter = 5.
  - Stimulus: sel 2 in the same cycle as a counter 1→0 edge.
  - Required response: `irq_n` stays 1.
- Latch 0:
  - Stimulus: latch 0, enabled, 3 edges.
  - Required response without the macro: `irq_n` low after the first edge.
  - Required response with `MMC3_ALT_IRQ_EN`: `irq_n` stays high.
- Reset mid-operation:
  - Stimulus: assert `reset` while the IRQ is pending and an A12 rise is in the synchronizer.
  - Required response: the next cycle shows `irq_n` = 1 and `counter_dbg` = 0, and no edge is counted afterwards.

Source files
------------

// File: rtl/mmc3_scanline_irq.sv
// rtl/mmc3_scanline_irq.sv - MMC3 scanline IRQ: filtered PPU A12 edge counter with latch/reload/enable
// Define MMC3_ALT_IRQ_EN for Rev A (NEC) IRQ behaviour; default is Rev B (Sharp).
module mmc3_scanline_irq #(
  parameter int A12_LOW_MIN = 3,
  parameter int FILTER_BITS = 2
) (
  input  logic       m2,
  input  logic       reset,
  input  logic       ppu_a12,
  input  logic       reg_wr,
  input  logic [1:0] reg_sel,
  input  logic [7:0] reg_data,
  output logic       irq_n,
  output logic [7:0] counter_dbg
);

  localparam logic [1:0] SEL_LATCH   = 2'd0;
  localparam logic [1:0] SEL_RELOAD  = 2'd1;
  localparam logic [1:0] SEL_DISABLE = 2'd2;
  localparam logic [1:0] SEL_ENABLE  = 2'd3;

  localparam logic [FILTER_BITS-1:0] LOW_MAX = FILTER_BITS'(A12_LOW_MIN);

  logic                   a12_meta_q, a12_meta_d;
  logic                   a12_s_q, a12_s_d;
  logic                   a12_d_q, a12_d_d;
  logic [FILTER_BITS-1:0] low_cnt_q, low_cnt_d;
  logic [7:0]             latch_q, latch_d;
  logic [7:0]             counter_q, counter_d;
  logic                   reload_q, reload_d;
  logic                   enabled_q, enabled_d;
  logic                   pending_q, pending_d;

  logic       a12_edge;
  logic       load_path;
  logic       irq_cond;
  logic [7:0] latch_w;
  logic [7:0] counter_w;
  logic       reload_w;
  logic       enabled_w;
  logic       pending_w;

  always_comb begin
    a12_meta_d = ppu_a12;
    a12_s_d    = a12_meta_q;
    a12_d_d    = a12_s_q;

    // A rise only counts after A12 has been low long enough; sprite-fetch pulses are rejected.
    low_cnt_d = low_cnt_q;
    if (a12_s_q) begin
      low_cnt_d = '0;
    end else if (low_cnt_q != LOW_MAX) begin
      low_cnt_d = low_cnt_q + FILTER_BITS'(1);
    end

    a12_edge = a12_s_q & ~a12_d_q & (low_cnt_q == LOW_MAX);

    // Register write is applied first; the edge then sees the post-write state.
    latch_w   = latch_q;
    counter_w = counter_q;
    reload_w  = reload_q;
    enabled_w = enabled_q;
    pending_w = pending_q;
    if (reg_wr) begin
      case (reg_sel)
        SEL_LATCH:   latch_w = reg_data;
        SEL_RELOAD: begin
          counter_w = 8'd0;
          reload_w  = 1'b1;
        end
        SEL_DISABLE: begin
          enabled_w = 1'b0;
          pending_w = 1'b0;
        end
        SEL_ENABLE:  enabled_w = 1'b1;
        default:     enabled_w = enabled_q;
      endcase
    end

    latch_d   = latch_w;
    counter_d = counter_w;
    reload_d  = reload_w;
    load_path = 1'b0;
    if (a12_edge) begin
      if ((counter_w == 8'd0) || reload_w) begin
        counter_d = latch_w;
        reload_d  = 1'b0;
        load_path = 1'b1;
      end else begin
        counter_d = counter_w - 8'd1;
      end
    end

`ifdef MMC3_ALT_IRQ_EN
    // Rev A: a reload from a zero latch never raises the IRQ.
    irq_cond = a12_edge && (counter_d == 8'd0) && (!load_path || (latch_w != 8'd0));
`else
    irq_cond = a12_edge && (counter_d == 8'd0);
`endif

    enabled_d = enabled_w;
    pending_d = pending_w | (irq_cond & enabled_w);
  end

  always_ff @(posedge m2) begin
    if (reset) begin
      a12_meta_q <= 1'b0;
      a12_s_q    <= 1'b0;
      a12_d_q    <= 1'b0;
      low_cnt_q  <= '0;
      latch_q    <= 8'd0;
      counter_q  <= 8'd0;
      reload_q   <= 1'b0;
      enabled_q  <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      a12_meta_q <= a12_meta_d;
      a12_s_q    <= a12_s_d;
      a12_d_q    <= a12_d_d;
      low_cnt_q  <= low_cnt_d;
      latch_q    <= latch_d;
      counter_q  <= counter_d;
      reload_q   <= reload_d;
      enabled_q  <= enabled_d;
      pending_q  <= pending_d;
    end
  end

  assign irq_n       = ~pending_q;
  assign counter_dbg = counter_q;

endmodule

// File: tb/tb_mmc3_scanline_irq.sv
// tb/tb_mmc3_scanline_irq.sv - directed vector bench for mmc3_scanline_irq
module tb_mmc3_scanline_irq;

  logic       m2 = 1'b0;
  logic       reset = 1'b1;
  logic       ppu_a12 = 1'b0;
  logic       reg_wr = 1'b0;
  logic [1:0] reg_sel = 2'd0;
  logic [7:0] reg_data = 8'd0;
  logic       irq_n;
  logic [7:0] counter_dbg;

  int checks = 0;
  int errors = 0;

  always #5 m2 = ~m2;

  mmc3_scanline_irq #(.A12_LOW_MIN(3), .FILTER_BITS(2)) dut (
    .m2(m2),
    .reset(reset),
    .ppu_a12(ppu_a12),
    .reg_wr(reg_wr),
    .reg_sel(reg_sel),
    .reg_data(reg_data),
    .irq_n(irq_n),
    .counter_dbg(counter_dbg)
  );

  localparam int OP_WR      = 0;
  localparam int OP_PULSE   = 1;
  localparam int OP_GLITCH  = 2;
  localparam int OP_EDGE_WR = 3;

`ifdef MMC3_ALT_IRQ_EN
  localparam logic L0_IRQ_N = 1'b1;
`else
  localparam logic L0_IRQ_N = 1'b0;
`endif

  typedef struct {
    int         op;
    logic [1:0] sel;
    logic [7:0] data;
    logic [7:0] exp_cnt;
    logic       exp_irq_n;
  } vec_t;

  vec_t vecs[30];

  task automatic tick();
    @(posedge m2);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_wr(input logic [1:0] sel, input logic [7:0] data);
    reg_wr = 1'b1;
    reg_sel = sel;
    reg_data = data;
    tick();
    reg_wr = 1'b0;
  endtask

  task automatic do_pulse(input int hi, input int lo);
    ppu_a12 = 1'b1;
    repeat (hi) tick();
    ppu_a12 = 1'b0;
    repeat (lo) tick();
  endtask

  // Write lands in the cycle where the synchronized A12 first reads high.
  task automatic do_edge_wr(input logic [1:0] sel, input logic [7:0] data);
    ppu_a12 = 1'b1;
    tick();
    tick();
    ppu_a12 = 1'b0;
    do_wr(sel, data);
    repeat (7) tick();
  endtask

  initial begin
    vecs[0]  = '{OP_WR,      2'd0, 8'd3, 8'd0, 1'b1};
    vecs[1]  = '{OP_WR,      2'd1, 8'd0, 8'd0, 1'b1};
    vecs[2]  = '{OP_WR,      2'd3, 8'd0, 8'd0, 1'b1};
    vecs[3]  = '{OP_PULSE,   2'd0, 8'd0, 8'd3, 1'b1};
    vecs[4]  = '{OP_PULSE,   2'd0, 8'd0, 8'd2, 1'b1};
    vecs[5]  = '{OP_PULSE,   2'd0, 8'd0, 8'd1, 1'b1};
    vecs[6]  = '{OP_PULSE,   2'd0, 8'd0, 8'd0, 1'b0};
    vecs[7]  = '{OP_PULSE,   2'd0, 8'd0, 8'd3, 1'b0};
    vecs[8]  = '{OP_PULSE,   2'd0, 8'd0, 8'd2, 1'b0};
    vecs[9]  = '{OP_WR,      2'd2, 8'd0, 8'd2, 1'b1};
    vecs[10] = '{OP_GLITCH,  2'd0, 8'd0, 8'd1, 1'b1};
    vecs[11] = '{OP_WR,      2'd3, 8'd0, 8'd1, 1'b1};
    vecs[12] = '{OP_EDGE_WR, 2'd2, 8'd0, 8'd0, 1'b1};
    vecs[13] = '{OP_EDGE_WR, 2'd0, 8'd5, 8'd5, 1'b1};
    vecs[14] = '{OP_WR,      2'd0, 8'd0, 8'd5, 1'b1};
    vecs[15] = '{OP_WR,      2'd3, 8'd0, 8'd5, 1'b1};
    vecs[16] = '{OP_WR,      2'd1, 8'd0, 8'd0, 1'b1};
    vecs[17] = '{OP_PULSE,   2'd0, 8'd0, 8'd0, L0_IRQ_N};
    vecs[18] = '{OP_PULSE,   2'd0, 8'd0, 8'd0, L0_IRQ_N};
    vecs[19] = '{OP_PULSE,   2'd0, 8'd0, 8'd0, L0_IRQ_N};
    vecs[20] = '{OP_WR,      2'd2, 8'd0, 8'd0, 1'b1};
    vecs[21] = '{OP_WR,      2'd0, 8'd2, 8'd0, 1'b1};
    vecs[22] = '{OP_WR,      2'd1, 8'd0, 8'd0, 1'b1};
    vecs[23] = '{OP_PULSE,   2'd0, 8'd0, 8'd2, 1'b1};
    vecs[24] = '{OP_PULSE,   2'd0, 8'd0, 8'd1, 1'b1};
    vecs[25] = '{OP_EDGE_WR, 2'd3, 8'd0, 8'd0, 1'b0};
    vecs[26] = '{OP_WR,      2'd2, 8'd0, 8'd0, 1'b1};
    vecs[27] = '{OP_WR,      2'd3, 8'd0, 8'd0, 1'b1};
    vecs[28] = '{OP_PULSE,   2'd0, 8'd0, 8'd2, 1'b1};
    vecs[29] = '{OP_PULSE,   2'd0, 8'd0, 8'd1, 1'b1};

    reset = 1'b1;
    tick();
    tick();
    check("reset_irq_n", {7'd0, irq_n}, 8'd1);
    check("reset_counter", counter_dbg, 8'd0);
    reset = 1'b0;
    repeat (5) tick();

    for (int i = 0; i < 30; i++) begin
      case (vecs[i].op)
        OP_WR:      do_wr(vecs[i].sel, vecs[i].data);
        OP_PULSE:   do_pulse(2, 8);
        OP_GLITCH: begin
          do_pulse(2, 2);
          do_pulse(2, 8);
        end
        default:    do_edge_wr(vecs[i].sel, vecs[i].data);
      endcase
      check($sformatf("vec%0d_counter", i), counter_dbg, vecs[i].exp_cnt);
      check($sformatf("vec%0d_irq_n", i), {7'd0, irq_n}, {7'd0, vecs[i].exp_irq_n});
    end

    // Exact latency: counter 1 -> 0, irq_n falls on the third cycle after the pin rise.
    ppu_a12 = 1'b1;
    tick();
    check("lat_c1_irq_n", {7'd0, irq_n}, 8'd1);
    tick();
    check("lat_c2_irq_n", {7'd0, irq_n}, 8'd1);
    check("lat_c2_counter", counter_dbg, 8'd1);
    tick();
    check("lat_c3_irq_n", {7'd0, irq_n}, 8'd0);
    check("lat_c3_counter", counter_dbg, 8'd0);
    ppu_a12 = 1'b0;
    repeat (8) tick();

    // Reset while pending and with a rise inside the synchronizer.
    ppu_a12 = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_irq_n", {7'd0, irq_n}, 8'd1);
    check("rst_mid_counter", counter_dbg, 8'd0);
    do_wr(2'd0, 8'd4);
    do_wr(2'd1, 8'd0);
    do_wr(2'd3, 8'd0);
    repeat (5) tick();
    check("rst_no_edge_counter", counter_dbg, 8'd0);
    check("rst_no_edge_irq_n", {7'd0, irq_n}, 8'd1);
    ppu_a12 = 1'b0;
    repeat (8) tick();
    do_pulse(2, 8);
    check("rst_after_counter", counter_dbg, 8'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
